// File: rtl/interrupt_issuer_if.sv
// interrupt_issuer_if
//   Groups the event/issue signals of interrupt_issuer into one bundle.
//   slave  : the issuer itself (consumes events/enable, drives the outputs).
//   master : whoever drives the events and watches the injected instructions.
// Signals:
//   event_in              N_EVENTS       asynchronous active-high event lines
//   enable                1              issuing allowed when 1
//   interrupt_instruction 32             injected instruction, 0 when none
//   pending_count         $clog2(DEPTH)+1 FIFO occupancy
//   overflow              1              sticky dropped-event flag
interface interrupt_issuer_if #(
  parameter int N_EVENTS = 4,
  parameter int DEPTH    = 4
);
  logic [N_EVENTS-1:0]      event_in;
  logic                     enable;
  logic [31:0]              interrupt_instruction;
  logic [$clog2(DEPTH):0]   pending_count;
  logic                     overflow;

  modport master (
    output event_in, enable,
    input  interrupt_instruction, pending_count, overflow
  );

  modport slave (
    input  event_in, enable,
    output interrupt_instruction, pending_count, overflow
  );
endinterface

// File: rtl/interrupt_issuer.sv
// interrupt_issuer
//   Producer for the processor's interrupt_instruction input. Asynchronous
//   game I/O events are synchronised, edge-detected, latched as pending bits,
//   queued in a small FIFO and issued one at a time as a single-cycle addi
//   that writes the event code (line index + 1) into TARGET_REG. After each
//   issue a guard gap of GAP_CYCLES idle cycles lets the pipeline absorb it.
// Ports:
//   clock  system clock
//   reset  synchronous active-high reset
//   bus    interrupt_issuer_if.slave (event_in, enable in;
//          interrupt_instruction, pending_count, overflow out)
module interrupt_issuer #(
  parameter int          N_EVENTS   = 4,
  parameter int          DEPTH      = 4,
  parameter int          GAP_CYCLES = 8,
  parameter logic [4:0]  TARGET_REG = 5'd28
) (
  input  logic               clock,
  input  logic               reset,
  interrupt_issuer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  logic [N_EVENTS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [N_EVENTS-1:0] pending_q, pending_d;
  logic [N_EVENTS-1:0] rise, clear_mask;
  logic [4:0]          mem_q [DEPTH];
  logic [4:0]          mem_d [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  state_t              state_q, state_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [31:0]         instr_q, instr_d;
  logic                push, pop, fifo_full, fifo_empty;
  logic [4:0]          push_code;

  // Two-flop synchronizer followed by rising-edge detect on the synced level.
  always_comb begin
    sync1_d = bus.event_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise    = sync2_q & ~prev_q;
  end

  // Pick the lowest pending line for this cycle's enqueue. The loop runs
  // high-to-low so the last match (lowest index) wins.
  always_comb begin
    push_code  = '0;
    clear_mask = '0;
    fifo_full  = (count_q == CW'(DEPTH));
    fifo_empty = (count_q == '0);
    push       = (pending_q != '0) && !fifo_full;
    for (int i = N_EVENTS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_code  = 5'(i + 1);
        clear_mask = N_EVENTS'(1) << i;
      end
    end
    if (!push) clear_mask = '0;
  end

  // A fresh edge on a bit being cleared this cycle is a new event, not a
  // drop; only an edge on a bit that stays set is lost.
  always_comb begin
    pending_d  = (pending_q & ~clear_mask) | rise;
    overflow_d = overflow_q | (|(rise & pending_q & ~clear_mask));
  end

  // FIFO storage; pointers wrap naturally at DEPTH (power of two) and the
  // count alone tells full from empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_code;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue FSM next-state: ISSUE lasts one cycle, GAP exactly GAP_CYCLES.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (pop) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = GAP;
        gap_d   = GW'(GAP_CYCLES);
      end
      GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue FSM outputs: the pop and the instruction register load happen on
  // the same edge, so the instruction is visible exactly during ISSUE.
  always_comb begin
    pop     = (state_q == IDLE) && bus.enable && !fifo_empty;
    instr_d = pop ? {5'b00101, TARGET_REG, 5'd0, 12'd0, mem_q[rd_ptr_q]} : 32'd0;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      gap_q      <= '0;
      instr_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      instr_q    <= instr_d;
    end
  end

  assign bus.interrupt_instruction = instr_q;
  assign bus.pending_count         = count_q;
  assign bus.overflow              = overflow_q;
endmodule

// File: tb/tb_interrupt_issuer.sv
// tb_interrupt_issuer
//   Drives interrupt_issuer through directed scenarios and a random run,
//   comparing every cycle against a queue-based reference model and checking
//   scenario-specific timing and code values.
module tb_interrupt_issuer;
  localparam int          N_EVENTS   = 4;
  localparam int          DEPTH      = 4;
  localparam int          GAP_CYCLES = 8;
  localparam int          SPACING    = GAP_CYCLES + 2;
  localparam int          CW         = $clog2(DEPTH) + 1;
  localparam logic [4:0]  TARGET_REG = 5'd28;
  localparam logic [N_EVENTS-1:0] ONE = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  interrupt_issuer_if #(.N_EVENTS(N_EVENTS), .DEPTH(DEPTH)) bus ();

  interrupt_issuer #(
    .N_EVENTS(N_EVENTS), .DEPTH(DEPTH),
    .GAP_CYCLES(GAP_CYCLES), .TARGET_REG(TARGET_REG)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: event sample history, pending bits, a queue of codes
  // and a minimum start-to-start spacing rule for issues.
  logic [N_EVENTS-1:0] m_h1 = '0, m_h2 = '0, m_h3 = '0, m_pend = '0;
  logic [N_EVENTS-1:0] m_rise, m_clr;
  int                  m_q[$];
  int                  m_edge_no = 0;
  int                  m_last_pop = -100;
  int                  m_sel;
  logic                m_ovf = 1'b0;
  logic [31:0]         m_instr = '0;
  logic [CW-1:0]       m_cnt = '0;
  bit                  m_pop, m_push;

  always @(posedge clock) begin
    m_edge_no++;
    if (reset) begin
      m_h1 = '0; m_h2 = '0; m_h3 = '0; m_pend = '0;
      m_q.delete();
      m_last_pop = -100;
      m_ovf = 1'b0;
      m_instr = '0;
    end else begin
      // An input level sampled at edge T shows up as a rise at edge T+2.
      m_rise = m_h2 & ~m_h3;
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = bus.event_in;
      m_pop  = bus.enable && (m_q.size() > 0) && (m_edge_no - m_last_pop >= SPACING);
      m_push = (m_pend != '0) && (m_q.size() < DEPTH);
      m_clr = '0;
      m_instr = '0;
      if (m_pop) begin
        m_instr = {5'b00101, TARGET_REG, 5'd0, 12'd0, 5'(m_q.pop_front())};
        m_last_pop = m_edge_no;
      end
      if (m_push) begin
        m_sel = -1;
        for (int i = N_EVENTS - 1; i >= 0; i--) if (m_pend[i]) m_sel = i;
        m_clr[m_sel] = 1'b1;
        m_q.push_back(m_sel + 1);
      end
      if ((m_rise & m_pend & ~m_clr) != '0) m_ovf = 1'b1;
      m_pend = (m_pend & ~m_clr) | m_rise;
    end
    m_cnt = CW'(m_q.size());
  end

  task automatic applyStimulus(input logic [N_EVENTS-1:0] ev, input logic en, input logic rst);
    bus.event_in = ev;
    bus.enable   = en;
    reset        = rst;
    @(negedge clock);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus('0, 1'b1, 1'b1);
      total++;
      if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
        bad++;
        $display("[TB] FAIL model_reset t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                 $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
      end
    end
    total++;
    if (bus.interrupt_instruction !== 32'd0 || bus.pending_count !== '0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state got instr=%h cnt=%0d ovf=%b want 0/0/0",
               bus.interrupt_instruction, bus.pending_count, bus.overflow);
    end
  endtask

  task automatic test_single_pulse();
    int first_k = -1;
    int n_issue = 0;
    logic [31:0]   seen = '0;
    logic [CW-1:0] cnt4 = '0, cnt5 = '1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus((k <= 3) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
      total++;
      if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
        bad++;
        $display("[TB] FAIL model_single t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                 $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
      end
      if (bus.interrupt_instruction != 32'd0) begin
        n_issue++;
        if (first_k < 0) first_k = k;
        seen = bus.interrupt_instruction;
      end
      if (k == 4) cnt4 = bus.pending_count;
      if (k == 5) cnt5 = bus.pending_count;
    end
    total++;
    if (n_issue != 1 || first_k != 5 || seen !== 32'h2F000003) begin
      bad++;
      $display("[TB] FAIL single_issue got n=%0d k=%0d instr=%h want n=1 k=5 instr=2f000003", n_issue, first_k, seen);
    end
    total++;
    if (cnt4 !== CW'(1) || cnt5 !== CW'(0) || bus.overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_count got cnt4=%0d cnt5=%0d ovf=%b want 1/0/0", cnt4, cnt5, bus.overflow);
    end
  endtask

  task automatic test_simultaneous();
    int k1 = -1, k4 = -1;
    for (int k = 1; k <= 30; k++) begin
      applyStimulus((k <= 3) ? 4'b1001 : 4'b0000, 1'b1, 1'b0);
      total++;
      if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
        bad++;
        $display("[TB] FAIL model_simul t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                 $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
      end
      if (bus.interrupt_instruction == 32'h2F000001) k1 = k;
      if (bus.interrupt_instruction == 32'h2F000004) k4 = k;
    end
    total++;
    if (k1 != 5 || k4 != 5 + SPACING) begin
      bad++;
      $display("[TB] FAIL simul_order got k1=%0d k4=%0d want k1=5 k4=%0d", k1, k4, 5 + SPACING);
    end
  endtask

  task automatic test_backpressure();
    int lines[5]     = '{0, 1, 2, 3, 0};
    int exp_codes[5] = '{1, 2, 3, 4, 1};
    int got_code[$];
    int got_k[$];
    foreach (lines[p]) begin
      for (int c = 0; c < 5; c++) begin
        applyStimulus((c < 2) ? (ONE << lines[p]) : '0, 1'b0, 1'b0);
        total++;
        if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
          bad++;
          $display("[TB] FAIL model_bp_fill t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                   $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
        end
      end
    end
    for (int c = 0; c < 6; c++) applyStimulus('0, 1'b0, 1'b0);
    total++;
    if (bus.pending_count !== CW'(DEPTH) || bus.overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_saturate got cnt=%0d ovf=%b want cnt=%0d ovf=0", bus.pending_count, bus.overflow, DEPTH);
    end
    for (int k = 1; k <= 60; k++) begin
      applyStimulus('0, 1'b1, 1'b0);
      total++;
      if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
        bad++;
        $display("[TB] FAIL model_bp_drain t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                 $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
      end
      if (bus.interrupt_instruction != 32'd0) begin
        got_code.push_back(int'(bus.interrupt_instruction[4:0]));
        got_k.push_back(k);
      end
    end
    total++;
    if (got_code.size() != 5) begin
      bad++;
      $display("[TB] FAIL bp_issue_count got %0d want 5", got_code.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got_code[i] != exp_codes[i]) begin
          bad++;
          $display("[TB] FAIL bp_code[%0d] got %0d want %0d", i, got_code[i], exp_codes[i]);
        end
      end
      for (int i = 1; i < 5; i++) begin
        total++;
        if (got_k[i] - got_k[i-1] != SPACING) begin
          bad++;
          $display("[TB] FAIL bp_spacing[%0d] got %0d want %0d", i, got_k[i] - got_k[i-1], SPACING);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int lines[6] = '{0, 2, 3, 0, 1, 1};
    int n_issue = 0;
    foreach (lines[p]) begin
      for (int c = 0; c < 5; c++) begin
        applyStimulus((c < 2) ? (ONE << lines[p]) : '0, 1'b0, 1'b0);
        total++;
        if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
          bad++;
          $display("[TB] FAIL model_ovf_fill t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                   $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
        end
      end
    end
    applyStimulus('0, 1'b0, 1'b0);
    total++;
    if (bus.overflow !== 1'b1 || bus.pending_count !== CW'(DEPTH)) begin
      bad++;
      $display("[TB] FAIL ovf_set got ovf=%b cnt=%0d want ovf=1 cnt=%0d", bus.overflow, bus.pending_count, DEPTH);
    end
    for (int k = 1; k <= 70; k++) begin
      applyStimulus('0, 1'b1, 1'b0);
      total++;
      if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
        bad++;
        $display("[TB] FAIL model_ovf_drain t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                 $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
      end
      if (bus.interrupt_instruction != 32'd0) n_issue++;
    end
    total++;
    if (n_issue != 5 || bus.overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_drain got issued=%0d ovf=%b want issued=5 ovf=1", n_issue, bus.overflow);
    end
  endtask

  task automatic test_reset_during_gap();
    int n_issue = 0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus((k <= 3) ? 4'b0111 : 4'b0000, 1'b1, 1'b0);
      total++;
      if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
        bad++;
        $display("[TB] FAIL model_gap t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                 $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
      end
    end
    total++;
    if (bus.pending_count !== CW'(2)) begin
      bad++;
      $display("[TB] FAIL gap_queued got cnt=%0d want 2", bus.pending_count);
    end
    applyStimulus('0, 1'b1, 1'b1);
    total++;
    if (bus.interrupt_instruction !== 32'd0 || bus.pending_count !== '0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL gap_reset got instr=%h cnt=%0d ovf=%b want 0/0/0",
               bus.interrupt_instruction, bus.pending_count, bus.overflow);
    end
    for (int k = 1; k <= 30; k++) begin
      applyStimulus('0, 1'b1, 1'b0);
      if (bus.interrupt_instruction != 32'd0) n_issue++;
    end
    total++;
    if (n_issue != 0 || bus.pending_count !== '0) begin
      bad++;
      $display("[TB] FAIL gap_quiet got issued=%0d cnt=%0d want 0/0", n_issue, bus.pending_count);
    end
  endtask

  task automatic test_held_through_reset();
    int n_code2 = 0;
    int n_other = 0;
    for (int k = 0; k < 2; k++) applyStimulus(4'b0010, 1'b1, 1'b1);
    for (int k = 1; k <= 45; k++) begin
      applyStimulus((k <= 40) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
      total++;
      if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
        bad++;
        $display("[TB] FAIL model_held t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                 $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
      end
      if (bus.interrupt_instruction == 32'h2F000002) n_code2++;
      else if (bus.interrupt_instruction != 32'd0) n_other++;
    end
    total++;
    if (n_code2 != 1 || n_other != 0) begin
      bad++;
      $display("[TB] FAIL held_once got code2=%0d other=%0d want 1/0", n_code2, n_other);
    end
  endtask

  task automatic test_random();
    logic [N_EVENTS-1:0] ev = '0;
    logic en, rst;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N_EVENTS; i++) if ($urandom_range(0, 5) == 0) ev[i] = ~ev[i];
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(ev, en, rst);
      total++;
      if ({bus.interrupt_instruction, bus.pending_count, bus.overflow} !== {m_instr, m_cnt, m_ovf}) begin
        bad++;
        $display("[TB] FAIL model_random t=%0t got instr=%h cnt=%0d ovf=%b want instr=%h cnt=%0d ovf=%b",
                 $time, bus.interrupt_instruction, bus.pending_count, bus.overflow, m_instr, m_cnt, m_ovf);
      end
    end
  endtask

  initial begin
    bus.event_in = '0;
    bus.enable   = 1'b1;
    reset        = 1'b1;
    test_reset();
    test_single_pulse();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_reset_during_gap();
    test_held_through_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/interrupt_issuer.md
Name: interrupt_issuer

Overview:
- Producer side of the processor's interrupt_instruction input.
- Captures asynchronous game I/O events (buttons/keys) and queues them in a small FIFO.
- Issues each event to the processor as a single-cycle 32-bit addi instruction that writes the event code into a fixed register.
- Enforces a guard gap between injections so the pipeline can absorb each one.

Parameters:
- N_EVENTS, 4: number of event input lines (1..16).
- DEPTH, 4: FIFO entries (power of 2, >=2).
- GAP_CYCLES, 8: idle cycles forced after each issued instruction (>=1).
- TARGET_REG, 5'd28: rd field of the issued addi.

Ports:
- clock  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- event_in  in  N_EVENTS  asynchronous event lines, active-high level.
- enable  in  1  1 = issuing allowed; 0 = capture continues, issuing paused.
- interrupt_instruction  out  32  injected instruction, 0 when none.
- pending_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset (synchronous, reset=1 at rising clock):
  - interrupt_instruction=0, pending_count=0, overflow=0.
  - FIFO empty, pending bits 0, synchronizers and previous-sample regs 0, FSM=IDLE, gap counter 0.
  - Reset mid-issue or mid-gap aborts immediately; queued events are lost.
  - A line held high through reset yields exactly one event after reset deasserts.
- Capture:
  - Each event_in[i] passes through a 2-flop synchronizer, then rising-edge detect (sync2 & ~prev).
  - A detected edge sets pending[i].
  - An edge on a line whose pending bit is already set is dropped and sets overflow (sticky until reset).
- Enqueue:
  - At most one per cycle, when pending != 0 and FIFO not full.
  - Selects the lowest set pending index i, writes code i+1 (5 bits) and clears pending[i].
  - Edge detect and clear of the same bit in the same cycle: bit stays set (new event).
  - FIFO full: pending bits hold (backpressure, no drop).
- Issue FSM:
  - IDLE: if enable=1 and FIFO not empty, pop head and go to ISSUE. The pop may coincide with an enqueue; occupancy is then unchanged.
  - ISSUE (1 cycle): interrupt_instruction = {5'b00101, TARGET_REG, 5'd0, 12'd0, code}. Load gap counter with GAP_CYCLES and go to GAP.
  - GAP: output 0; decrement the counter each cycle; go to IDLE when it reaches 0 (exactly GAP_CYCLES cycles in GAP).
  - enable=0 only blocks the IDLE->ISSUE transition; ISSUE and GAP always complete.
- Output:
  - interrupt_instruction is registered and is nonzero only in the ISSUE cycle.
  - Minimum spacing between two issued instructions is GAP_CYCLES+2 cycles start-to-start (ISSUE, GAP×N, IDLE).
- Latency (idle FSM, empty FIFO, enable=1):
  - event_in[i] first sampled high at edge E gives: sync2 at E+1, pending at E+2, FIFO write at E+3, ISSUE register load at E+4.
  - The instruction is visible in the cycle following E+4.
- pending_count: registered; updated on the same edge as the FIFO write/pop; range 0..DEPTH.
- Pointer wrap-around: modulo DEPTH. Full/empty are distinguished by the count, not by pointer equality.

Test Plan:
- Reset, then pulse event_in[2] for 3 cycles -> exactly one cycle of interrupt_instruction = 32'h2F000003 (rd=28, code 3) after edge E+4; overflow stays 0; pending_count 0->1->0.
- Set event_in[0] and event_in[3] high in the same cycle -> code 1 issued, then code 4 issued exactly GAP_CYCLES+2 = 10 cycles later.
- enable=0; generate 5 distinct edges on lines 0,1,2,3,0 (after line 0's first event is enqueued) -> pending_count saturates at 4, the fifth is held in pending with no drop. Set enable=1 -> codes 1,2,3,4,1 issued in order, spaced 10 cycles apart.
- With FIFO full and pending[1]=1, produce another rising edge on event_in[1] -> overflow=1 and remains 1 until reset; the total issued count is one less than the edges generated.
- Assert reset during GAP with 2 entries queued -> next cycle interrupt_instruction=0, pending_count=0, overflow=0; nothing further issues without new edges.
- Hold event_in[1]=1 through and after reset -> exactly one code-2 instruction issued, none repeated while held.
